// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, per-frame scan
// result and key-index / one-hot widths.
package keypad_scan_pkg;

  localparam int unsigned NumCols = 4;
  localparam int unsigned NumRows = 4;
  localparam int unsigned NumKeys = NumCols * NumRows;
  localparam int unsigned KeyIdxW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StPressConfirm,
    StHeld,
    StReleaseConfirm
  } key_state_e;

  typedef enum logic [1:0] {
    FrameNone,
    FrameKey,
    FrameMulti
  } frame_e;

  function automatic logic [NumKeys-1:0] key_to_onehot(input logic [KeyIdxW-1:0] idx);
    logic [NumKeys-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/keypad_col_seq.sv
// Column dwell counter and sequencer: walks one active-low column at a time and flags
// the last cycle of each dwell as the row sampling point.
module keypad_col_seq
  import keypad_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_out,
  output logic [1:0] col_idx,
  output logic       sample_en
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

  logic [DivW-1:0] div_q;
  logic [1:0]      col_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      col_q <= '0;
    end else if (div_q == DivLast) begin
      div_q <= '0;
      col_q <= col_q + 2'd1;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  assign sample_en = (div_q == DivLast);
  assign col_idx   = col_q;
  assign col_out   = ~(4'b0001 << col_q);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: builds a per-frame NONE/KEY/MULTI result from the column
// samples and debounces it through a press/release confirm FSM.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEBOUNCE_N = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          row_in,
  output logic [3:0]          col_out,
  output logic [NumKeys-1:0]  onehot,
  output logic                key_pulse,
  output logic                key_down
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_N + 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_N);

  logic [1:0] col_idx;
  logic       sample_en;

  keypad_col_seq #(
    .SCAN_DIV (SCAN_DIV)
  ) u_col_seq (
    .clk       (clk),
    .rst       (rst),
    .col_out   (col_out),
    .col_idx   (col_idx),
    .sample_en (sample_en)
  );

  // Frame accumulation across the four column samples
  logic [3:0]         rows_low;
  logic [2:0]         n_low;
  logic [1:0]         row_pos;
  logic               acc_any_q, acc_any_d;
  logic               acc_multi_q, acc_multi_d;
  logic [KeyIdxW-1:0] acc_idx_q, acc_idx_d;
  logic               base_any, base_multi;
  logic [KeyIdxW-1:0] base_idx;
  logic               frame_done;
  frame_e             frame_res;

  assign rows_low = ~row_in;

  always_comb begin
    n_low   = '0;
    row_pos = '0;
    for (int r = 0; r < 4; r++) begin
      n_low = n_low + {2'b00, rows_low[r]};
      if (rows_low[r]) row_pos = 2'(r);
    end
  end

  always_comb begin
    // Column 0 opens a fresh frame, so earlier samples are ignored there.
    base_any   = (col_idx == 2'd0) ? 1'b0 : acc_any_q;
    base_multi = (col_idx == 2'd0) ? 1'b0 : acc_multi_q;
    base_idx   = (col_idx == 2'd0) ? '0 : acc_idx_q;
    acc_multi_d = base_multi | (n_low > 3'd1) | ((n_low == 3'd1) & base_any);
    acc_any_d   = base_any | (n_low != 3'd0);
    acc_idx_d   = base_idx;
    if ((n_low == 3'd1) && !base_any) acc_idx_d = {col_idx, row_pos};
    frame_done = sample_en && (col_idx == 2'd3);
    if (acc_multi_d)    frame_res = FrameMulti;
    else if (acc_any_d) frame_res = FrameKey;
    else                frame_res = FrameNone;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_any_q   <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_idx_q   <= '0;
    end else if (sample_en) begin
      acc_any_q   <= acc_any_d;
      acc_multi_q <= acc_multi_d;
      acc_idx_q   <= acc_idx_d;
    end
  end

  // Debounce FSM
  key_state_e         state_q, state_d;
  logic [KeyIdxW-1:0] cand_q, cand_d;
  logic [CntW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [NumKeys-1:0] onehot_q, onehot_d;
  logic               key_pulse_q, key_pulse_d;
  logic               key_down_q, key_down_d;
  logic               is_cand;

  assign cnt_inc = cnt_q + CntOne;
  assign is_cand = (frame_res == FrameKey) && (acc_idx_d == cand_q);

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    onehot_d    = onehot_q;
    key_pulse_d = 1'b0;
    key_down_d  = key_down_q;
    if (frame_done) begin
      unique case (state_q)
        StIdle: begin
          if (frame_res == FrameKey) begin
            cand_d = acc_idx_d;
            cnt_d  = CntOne;
            if (CntOne >= CntMax) begin
              state_d     = StHeld;
              onehot_d    = key_to_onehot(acc_idx_d);
              key_pulse_d = 1'b1;
              key_down_d  = 1'b1;
            end else begin
              state_d = StPressConfirm;
            end
          end
        end
        StPressConfirm: begin
          if (is_cand) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CntMax) begin
              state_d     = StHeld;
              onehot_d    = key_to_onehot(cand_q);
              key_pulse_d = 1'b1;
              key_down_d  = 1'b1;
            end
          end else if (frame_res == FrameKey) begin
            cand_d = acc_idx_d;
            cnt_d  = CntOne;
          end else begin
            state_d = StIdle;
          end
        end
        StHeld: begin
          if (!is_cand) begin
            cnt_d = CntOne;
            if (CntOne >= CntMax) begin
              state_d    = StIdle;
              key_down_d = 1'b0;
            end else begin
              state_d = StReleaseConfirm;
            end
          end
        end
        StReleaseConfirm: begin
          if (is_cand) begin
            state_d = StHeld;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CntMax) begin
              state_d    = StIdle;
              key_down_d = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cand_q      <= '0;
      cnt_q       <= '0;
      onehot_q    <= '0;
      key_pulse_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      onehot_q    <= onehot_d;
      key_pulse_q <= key_pulse_d;
      key_down_q  <= key_down_d;
    end
  end

  assign onehot    = onehot_q;
  assign key_pulse = key_pulse_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_N=3 (16-cycle frames); a
// simple matrix model turns the set of pressed keys into row levels.
module tb_keypad_scan;

  localparam int unsigned ScanDiv = 4;
  localparam int unsigned DebN    = 3;
  localparam int          Frame   = 4 * ScanDiv;

  logic        clk;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] onehot;
  logic        key_pulse;
  logic        key_down;

  logic [15:0] pressed;
  logic [3:0]  exp_col;
  int          n_checks = 0;
  int          n_fails  = 0;
  int          pulse_cnt = 0;
  int          base;

  keypad_scan #(
    .SCAN_DIV   (ScanDiv),
    .DEBOUNCE_N (DebN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .onehot    (onehot),
    .key_pulse (key_pulse),
    .key_down  (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rows_for(input logic [3:0] cols, input logic [15:0] keys);
    logic [3:0] rows;
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!cols[c] && keys[4*c+r]) rows[r] = 1'b0;
    return rows;
  endfunction

  assign row_in = rows_for(col_out, pressed);

  always @(negedge clk) if (key_pulse === 1'b1) pulse_cnt++;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * Frame) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    pressed = '0;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_col", {12'h0, col_out}, 16'h000E);
      check_eq("rst_onehot", onehot, 16'h0000);
      check_eq("rst_pulse", {15'h0, key_pulse}, 16'h0);
      check_eq("rst_down", {15'h0, key_down}, 16'h0);
    end
    rst = 1'b0;

    // Column walk, full dwell on column 0 right after reset
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(4'b0001 << (i / 4));
      check_eq("col_seq", {12'h0, col_out}, {12'h0, exp_col});
      @(negedge clk);
    end

    // Key 9 (col2,row1): confirmed after 3 frames, pulse visible on the next cycle
    pressed = 16'h0200;
    base    = pulse_cnt;
    frames(3);
    check_eq("press_pulse_hi", {15'h0, key_pulse}, 16'h1);
    check_eq("press_onehot", onehot, 16'h0200);
    check_eq("press_down", {15'h0, key_down}, 16'h1);
    @(negedge clk);
    check_eq("press_pulse_lo", {15'h0, key_pulse}, 16'h0);
    repeat (Frame - 1) @(negedge clk);
    check_eq("press_one_pulse", 16'(pulse_cnt - base), 16'd1);
    frames(2);
    check_eq("held_no_repulse", 16'(pulse_cnt - base), 16'd1);
    check_eq("held_down", {15'h0, key_down}, 16'h1);

    // Release: key_down holds through two NONE frames and drops on the third
    pressed = '0;
    frames(2);
    check_eq("rel_partial_down", {15'h0, key_down}, 16'h1);
    frames(1);
    check_eq("rel_down", {15'h0, key_down}, 16'h0);
    check_eq("rel_onehot_kept", onehot, 16'h0200);

    // Re-press key 9
    pressed = 16'h0200;
    base    = pulse_cnt;
    frames(4);
    check_eq("repress_pulse", 16'(pulse_cnt - base), 16'd1);
    check_eq("repress_onehot", onehot, 16'h0200);
    check_eq("repress_down", {15'h0, key_down}, 16'h1);

    // Add key 6 while 9 is held: MULTI frames release, no pulse for the pair
    pressed = 16'h0240;
    base    = pulse_cnt;
    frames(3);
    check_eq("multi_down", {15'h0, key_down}, 16'h0);
    check_eq("multi_onehot", onehot, 16'h0200);
    frames(2);
    check_eq("multi_no_pulse", 16'(pulse_cnt - base), 16'd0);
    pressed = '0;
    frames(1);

    // Fresh reset, then key 9 only on alternate frames
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    base = pulse_cnt;
    for (int f = 0; f < 8; f++) begin
      pressed = (f % 2 == 0) ? 16'h0200 : 16'h0000;
      frames(1);
    end
    check_eq("alt_no_pulse", 16'(pulse_cnt - base), 16'd0);
    check_eq("alt_onehot", onehot, 16'h0000);

    // One frame of key 9 then key 6 steady: candidate is reloaded to 6
    base    = pulse_cnt;
    pressed = 16'h0200;
    frames(1);
    pressed = 16'h0040;
    frames(3);
    repeat (2) @(negedge clk);
    check_eq("reload_onehot", onehot, 16'h0040);
    check_eq("reload_pulse", 16'(pulse_cnt - base), 16'd1);
    check_eq("reload_down", {15'h0, key_down}, 16'h1);

    // Reset mid-dwell while HELD
    rst = 1'b1;
    @(negedge clk);
    check_eq("hrst_onehot", onehot, 16'h0000);
    check_eq("hrst_down", {15'h0, key_down}, 16'h0);
    check_eq("hrst_col", {12'h0, col_out}, 16'h000E);
    check_eq("hrst_pulse", {15'h0, key_pulse}, 16'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_col = (i < 4) ? 4'b1110 : 4'b1101;
      check_eq("hrst_restart", {12'h0, col_out}, {12'h0, exp_col});
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
